// File: rtl/rv_dbus_pkg.sv
// ============================================================================
// Module : rv_dbus_pkg
// Brief  : Shared types and helpers for the data-bus crossbar.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rv_dbus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOCAL = 2'd1,
      ST_EXT   = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [31:0] C_BUS_ERR_DATA = 32'h0000_0000;

   // Takes byte-address bits [31:16], i.e. word-address bits [29:14].
   function automatic logic is_local_adr(input logic [15:0] adr_hi,
                                         input logic [15:0] prefix,
                                         input logic        enable);
      return enable && (adr_hi == prefix);
   endfunction

endpackage

`default_nettype wire

// File: rtl/rv_dbus_wdog.sv
// ============================================================================
// Module : rv_dbus_wdog
// Brief  : Bus-cycle watchdog counter; expires at all-ones.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rv_dbus_wdog #(
   parameter int TIMEOUT_W = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam logic [TIMEOUT_W-1:0] C_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

   logic [TIMEOUT_W-1:0] count_q;
   logic [TIMEOUT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + C_ONE;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired_o = (count_q == '1);

endmodule

`default_nettype wire

// File: rtl/rv_dbus_xbar.sv
// ============================================================================
// Module : rv_dbus_xbar
// Brief  : Wishbone data-bus decoder/router with local/external slave and watchdog.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rv_dbus_xbar
   import rv_dbus_pkg::*;
#(
   parameter int          ENABLE_LOCALMAP = 1,
   parameter logic [15:0] LOCAL_PREFIX    = 16'hFFFF,
   parameter int          TIMEOUT_W       = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        m_cyc_i,
   input  logic        m_stb_i,
   input  logic        m_we_i,
   input  logic [3:0]  m_sel_i,
   input  logic [29:0] m_adr_i,
   input  logic [31:0] m_dat_i,
   output logic [31:0] m_dat_o,
   output logic        m_ack_o,
   output logic        m_err_o,
   output logic [29:0] s_adr_o,
   output logic [31:0] s_dat_o,
   output logic [3:0]  s_sel_o,
   output logic        s_we_o,
   output logic        l_cyc_o,
   output logic        l_stb_o,
   input  logic [31:0] l_dat_i,
   input  logic        l_ack_i,
   output logic        x_cyc_o,
   output logic        x_stb_o,
   input  logic [31:0] x_dat_i,
   input  logic        x_ack_i,
   output logic [29:0] err_adr_o
);

   state_e      state_q, state_d;
   logic [29:0] s_adr_q, s_adr_d;
   logic [31:0] s_dat_q, s_dat_d;
   logic [3:0]  s_sel_q, s_sel_d;
   logic        s_we_q, s_we_d;
   logic        l_cyc_q, l_cyc_d;
   logic        x_cyc_q, x_cyc_d;
   logic        m_ack_q, m_ack_d;
   logic        m_err_q, m_err_d;
   logic [31:0] m_dat_q, m_dat_d;
   logic [29:0] err_adr_q, err_adr_d;

   logic        w_active;
   logic        w_slv_ack;
   logic [31:0] w_slv_dat;
   logic        w_expired;

   assign w_active  = (state_q == ST_LOCAL) || (state_q == ST_EXT);
   // Only the slave that owns the cycle may complete it.
   assign w_slv_ack = (state_q == ST_LOCAL) ? l_ack_i :
                      (state_q == ST_EXT)   ? x_ack_i : 1'b0;
   assign w_slv_dat = (state_q == ST_LOCAL) ? l_dat_i : x_dat_i;

   rv_dbus_wdog #(
      .TIMEOUT_W (TIMEOUT_W)
   ) u_wdog (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (state_q == ST_IDLE),
      .en_i      (w_active),
      .expired_o (w_expired)
   );

   always_comb begin
      state_d   = state_q;
      s_adr_d   = s_adr_q;
      s_dat_d   = s_dat_q;
      s_sel_d   = s_sel_q;
      s_we_d    = s_we_q;
      l_cyc_d   = l_cyc_q;
      x_cyc_d   = x_cyc_q;
      m_ack_d   = 1'b0;
      m_err_d   = 1'b0;
      m_dat_d   = m_dat_q;
      err_adr_d = err_adr_q;
      case (state_q)
         ST_IDLE: begin
            if (m_cyc_i && m_stb_i) begin
               s_adr_d = m_adr_i;
               s_dat_d = m_dat_i;
               s_sel_d = m_sel_i;
               s_we_d  = m_we_i;
               if (is_local_adr(m_adr_i[29:14], LOCAL_PREFIX, ENABLE_LOCALMAP != 0)) begin
                  l_cyc_d = 1'b1;
                  state_d = ST_LOCAL;
               end else begin
                  x_cyc_d = 1'b1;
                  state_d = ST_EXT;
               end
            end
         end
         ST_LOCAL, ST_EXT: begin
            if (!m_cyc_i) begin
               l_cyc_d = 1'b0;
               x_cyc_d = 1'b0;
               state_d = ST_IDLE;
            end else if (w_slv_ack) begin
               // Ack beats a simultaneous watchdog expiry.
               l_cyc_d = 1'b0;
               x_cyc_d = 1'b0;
               m_ack_d = 1'b1;
               m_dat_d = w_slv_dat;
               state_d = ST_DONE;
            end else if (w_expired) begin
               l_cyc_d   = 1'b0;
               x_cyc_d   = 1'b0;
               m_ack_d   = 1'b1;
               m_err_d   = 1'b1;
               m_dat_d   = C_BUS_ERR_DATA;
               err_adr_d = s_adr_q;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         s_adr_q   <= '0;
         s_dat_q   <= '0;
         s_sel_q   <= '0;
         s_we_q    <= 1'b0;
         l_cyc_q   <= 1'b0;
         x_cyc_q   <= 1'b0;
         m_ack_q   <= 1'b0;
         m_err_q   <= 1'b0;
         m_dat_q   <= '0;
         err_adr_q <= '0;
      end else begin
         state_q   <= state_d;
         s_adr_q   <= s_adr_d;
         s_dat_q   <= s_dat_d;
         s_sel_q   <= s_sel_d;
         s_we_q    <= s_we_d;
         l_cyc_q   <= l_cyc_d;
         x_cyc_q   <= x_cyc_d;
         m_ack_q   <= m_ack_d;
         m_err_q   <= m_err_d;
         m_dat_q   <= m_dat_d;
         err_adr_q <= err_adr_d;
      end
   end

   assign m_dat_o   = m_dat_q;
   assign m_ack_o   = m_ack_q;
   assign m_err_o   = m_err_q;
   assign s_adr_o   = s_adr_q;
   assign s_dat_o   = s_dat_q;
   assign s_sel_o   = s_sel_q;
   assign s_we_o    = s_we_q;
   assign l_cyc_o   = l_cyc_q;
   assign l_stb_o   = l_cyc_q;
   assign x_cyc_o   = x_cyc_q;
   assign x_stb_o   = x_cyc_q;
   assign err_adr_o = err_adr_q;

endmodule

`default_nettype wire

// File: tb/tb_rv_dbus_xbar.sv
// ============================================================================
// Module : tb_rv_dbus_xbar
// Brief  : Scoreboard bench for rv_dbus_xbar (local map on/off, TIMEOUT_W=4).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_rv_dbus_xbar;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        m_cyc_i, m_stb_i, m_we_i;
   logic [3:0]  m_sel_i;
   logic [29:0] m_adr_i;
   logic [31:0] m_dat_i;
   logic [31:0] m_dat_o;
   logic        m_ack_o, m_err_o;
   logic [29:0] s_adr_o;
   logic [31:0] s_dat_o;
   logic [3:0]  s_sel_o;
   logic        s_we_o;
   logic        l_cyc_o, l_stb_o, l_ack_i;
   logic [31:0] l_dat_i;
   logic        x_cyc_o, x_stb_o, x_ack_i;
   logic [31:0] x_dat_i;
   logic [29:0] err_adr_o;

   // Second instance with local decode disabled
   logic        b_cyc_i, b_stb_i;
   logic [31:0] b_dat_o;
   logic        b_ack_o, b_err_o;
   logic [29:0] b_s_adr_o;
   logic [31:0] b_s_dat_o;
   logic [3:0]  b_s_sel_o;
   logic        b_s_we_o;
   logic        bl_cyc_o, bl_stb_o, bx_cyc_o, bx_stb_o, bx_ack_i;
   logic [31:0] bx_dat_i;
   logic [29:0] b_err_adr_o;

   always #5 clk = ~clk;

   rv_dbus_xbar #(.ENABLE_LOCALMAP(1), .LOCAL_PREFIX(16'hFFFF), .TIMEOUT_W(4)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
      .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
      .m_err_o(m_err_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
      .s_we_o(s_we_o), .l_cyc_o(l_cyc_o), .l_stb_o(l_stb_o), .l_dat_i(l_dat_i),
      .l_ack_i(l_ack_i), .x_cyc_o(x_cyc_o), .x_stb_o(x_stb_o), .x_dat_i(x_dat_i),
      .x_ack_i(x_ack_i), .err_adr_o(err_adr_o)
   );

   rv_dbus_xbar #(.ENABLE_LOCALMAP(0), .LOCAL_PREFIX(16'hFFFF), .TIMEOUT_W(4)) dut_nomap (
      .clk_i(clk), .rst_i(rst_i),
      .m_cyc_i(b_cyc_i), .m_stb_i(b_stb_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
      .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(b_dat_o), .m_ack_o(b_ack_o),
      .m_err_o(b_err_o), .s_adr_o(b_s_adr_o), .s_dat_o(b_s_dat_o), .s_sel_o(b_s_sel_o),
      .s_we_o(b_s_we_o), .l_cyc_o(bl_cyc_o), .l_stb_o(bl_stb_o), .l_dat_i(32'h1111_1111),
      .l_ack_i(bx_ack_i), .x_cyc_o(bx_cyc_o), .x_stb_o(bx_stb_o), .x_dat_i(bx_dat_i),
      .x_ack_i(bx_ack_i), .err_adr_o(b_err_adr_o)
   );

   typedef struct {
      logic [31:0] dat;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every master ack consumes one expected completion.
   exp_t mon_e;
   always @(negedge clk) begin
      check("cyc_onehot", {31'd0, l_cyc_o & x_cyc_o}, 32'd0);
      if (m_ack_o) begin
         if (sb.size() == 0) begin
            check("unexpected_ack", {31'd0, m_ack_o}, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("m_dat_o", m_dat_o, mon_e.dat);
            check("m_err_o", {31'd0, m_err_o}, {31'd0, mon_e.err});
         end
      end else if (m_err_o) begin
         check("err_without_ack", {31'd0, m_err_o}, 32'd0);
      end
   end

   // waits < 0 means no slave ever acknowledges (timeout expected).
   task automatic access(input logic [29:0] adr, input logic [31:0] wdat, input logic [3:0] sel,
                         input logic we, input bit to_local, input int waits,
                         input logic [31:0] rdat, input bit exp_err);
      exp_t e;
      int   n;
      @(negedge clk);
      m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = we; m_sel_i = sel;
      m_adr_i = adr;  m_dat_i = wdat;
      e.dat = exp_err ? 32'h0 : rdat;
      e.err = exp_err;
      sb.push_back(e);
      // The non-selected slave keeps acking; it must be ignored.
      if (to_local) begin x_ack_i = 1'b1; x_dat_i = 32'hBADB_AD00; end
      else          begin l_ack_i = 1'b1; l_dat_i = 32'hBADB_AD00; end
      @(posedge clk); #1;
      check("sel_cyc", {31'd0, to_local ? l_cyc_o : x_cyc_o}, 32'd1);
      check("sel_stb", {31'd0, to_local ? l_stb_o : x_stb_o}, 32'd1);
      check("other_cyc", {31'd0, to_local ? x_cyc_o : l_cyc_o}, 32'd0);
      check("s_adr_o", {2'b0, s_adr_o}, {2'b0, adr});
      check("s_dat_o", s_dat_o, wdat);
      check("s_sel_we", {27'd0, s_sel_o, s_we_o}, {27'd0, sel, we});
      if (waits >= 0) begin
         for (int i = 0; i <= waits; i++) begin
            @(negedge clk);
            if (i == waits) begin
               if (to_local) begin l_ack_i = 1'b1; l_dat_i = rdat; end
               else          begin x_ack_i = 1'b1; x_dat_i = rdat; end
            end
            @(posedge clk); #1;
            if (i < waits)
               check("cyc_held", {31'd0, to_local ? l_cyc_o : x_cyc_o}, 32'd1);
         end
         check("ack_edge", {31'd0, m_ack_o}, 32'd1);
      end else begin
         n = 0;
         while (!m_ack_o && n < 40) begin
            @(posedge clk); #1;
            n++;
         end
         check("timeout_cycles", n, 16);
         check("err_adr_o", {2'b0, err_adr_o}, {2'b0, adr});
      end
      check("cyc_dropped", {30'd0, l_cyc_o, x_cyc_o}, 32'd0);
      l_ack_i = 1'b0; x_ack_i = 1'b0;
      m_cyc_i = 1'b0; m_stb_i = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_i = 1'b1;
      m_cyc_i = 0; m_stb_i = 0; m_we_i = 0; m_sel_i = 0; m_adr_i = 0; m_dat_i = 0;
      l_ack_i = 0; l_dat_i = 0; x_ack_i = 0; x_dat_i = 0;
      b_cyc_i = 0; b_stb_i = 0; bx_ack_i = 0; bx_dat_i = 0;
      #2;
      check("rst_m", {m_dat_o[30:0], m_ack_o} | {31'd0, m_err_o}, 32'd0);
      check("rst_s", s_dat_o | {2'b0, s_adr_o} | {27'd0, s_sel_o, s_we_o}, 32'd0);
      check("rst_cyc", {28'd0, l_cyc_o, l_stb_o, x_cyc_o, x_stb_o}, 32'd0);
      check("rst_err_adr", {2'b0, err_adr_o}, 32'd0);
      repeat (2) @(negedge clk);
      rst_i = 1'b0;

      // Acks while idle are ignored
      @(negedge clk); l_ack_i = 1; x_ack_i = 1;
      repeat (2) @(posedge clk); #1;
      check("idle_ack_ignored", {31'd0, m_ack_o}, 32'd0);
      l_ack_i = 0; x_ack_i = 0;

      // Local read at 0xFFFF0010
      access(30'h3FFF_C004, 32'h0, 4'hF, 1'b0, 1'b1, 0, 32'h1234_5678, 1'b0);
      // External byte write at 0x00001002, 3 wait states; read data captured anyway
      access(30'h0000_0400, 32'h00AB_0000, 4'b0100, 1'b1, 1'b0, 3, 32'hDEAD_0000, 1'b0);
      // Timeout on 0x20000000
      access(30'h0800_0000, 32'h0, 4'hF, 1'b0, 1'b0, -1, 32'h0, 1'b1);
      check("m_dat_hold", m_dat_o, 32'h0);
      // Ack coincides with expiry: ack wins
      access(30'h0000_0040, 32'h0, 4'hF, 1'b0, 1'b0, 15, 32'hCAFE_F00D, 1'b0);
      check("err_adr_sticky", {2'b0, err_adr_o}, 32'h0800_0000);
      check("m_dat_hold2", m_dat_o, 32'hCAFE_F00D);

      // Abort mid-EXT
      @(negedge clk);
      m_cyc_i = 1; m_stb_i = 1; m_we_i = 0; m_adr_i = 30'h0000_0100;
      @(posedge clk); #1;
      check("abort_start", {31'd0, x_cyc_o}, 32'd1);
      @(posedge clk);
      @(negedge clk); m_cyc_i = 0; m_stb_i = 0;
      @(posedge clk); #1;
      check("abort_cyc", {30'd0, x_cyc_o, x_stb_o}, 32'd0);
      check("abort_no_ack", {31'd0, m_ack_o}, 32'd0);
      @(posedge clk); #1;
      check("abort_no_ack2", {31'd0, m_ack_o}, 32'd0);

      // Asynchronous reset mid-LOCAL
      @(negedge clk);
      m_cyc_i = 1; m_stb_i = 1; m_adr_i = 30'h3FFF_C008;
      @(posedge clk); #1;
      check("pre_rst_cyc", {31'd0, l_cyc_o}, 32'd1);
      #2 rst_i = 1'b1;
      #1;
      check("async_rst_cyc", {28'd0, l_cyc_o, l_stb_o, x_cyc_o, x_stb_o}, 32'd0);
      check("async_rst_m", m_dat_o | {31'd0, m_ack_o | m_err_o}, 32'd0);
      check("async_rst_s", {2'b0, s_adr_o} | {2'b0, err_adr_o}, 32'd0);
      m_cyc_i = 0; m_stb_i = 0;
      @(negedge clk); rst_i = 1'b0;
      access(30'h3FFF_C00C, 32'h0, 4'hF, 1'b0, 1'b1, 1, 32'h0BAD_F00D, 1'b0);

      // Local decode disabled: 0xFFFF0000 goes external
      @(negedge clk);
      m_adr_i = 30'h3FFF_C000; m_we_i = 0; b_cyc_i = 1; b_stb_i = 1;
      bx_ack_i = 1; bx_dat_i = 32'h55AA_55AA;
      @(posedge clk); #1;
      check("nomap_x_cyc", {31'd0, bx_cyc_o}, 32'd1);
      check("nomap_l_cyc", {31'd0, bl_cyc_o}, 32'd0);
      @(posedge clk); #1;
      check("nomap_ack", {31'd0, b_ack_o}, 32'd1);
      check("nomap_dat", b_dat_o, 32'h55AA_55AA);
      check("nomap_l_cyc2", {31'd0, bl_cyc_o}, 32'd0);
      b_cyc_i = 0; b_stb_i = 0; bx_ack_i = 0;

      repeat (3) @(posedge clk);
      #1;
      check("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
